// File: rtl/pipeline_adder_arbiter.sv
// rtl/pipeline_adder_arbiter.sv - round-robin arbiter sharing one pipelined adder among NREQ requesters
// Optional multi-word carry chaining is built with `define PIPE_ARB_CHAIN_EN.
module pipeline_adder_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  parameter int LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
`ifdef PIPE_ARB_CHAIN_EN
  input  logic [NREQ-1:0]       req_chain,
`endif
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [LAT-1:0]        vld_q, vld_d;
  logic [LAT-1:0][PW-1:0] id_q, id_d;
  logic [NREQ-1:0]       elig;
  logic [PW:0]           idx;
  logic [PW-1:0]         win;
  logic                  transfer;
  logic                  rsp_vld;
  logic [PW-1:0]         rsp_id;

  assign rsp_vld = vld_q[LAT-1] & ~rst;
  assign rsp_id  = id_q[LAT-1];

`ifdef PIPE_ARB_CHAIN_EN
  logic [NREQ-1:0] carry_q;
  logic [NREQ-1:0] inflight;

  // Chained requests wait until the previous word's carry has landed in carry_q.
  always_comb begin
    inflight = '0;
    for (int s = 0; s < LAT; s++) begin
      if (vld_q[s]) inflight[id_q[s]] = 1'b1;
    end
  end

  assign elig = req_valid & ~(req_chain & inflight) & {NREQ{~rst}};

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= '0;
    end else if (rsp_vld) begin
      carry_q[rsp_id] <= add_cout;
    end
  end
`else
  assign elig = req_valid & {NREQ{~rst}};
`endif

  always_comb begin
    transfer = 1'b0;
    win      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!transfer && elig[idx[PW-1:0]]) begin
        transfer = 1'b1;
        win      = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = transfer && (win == PW'(i));
      rsp_valid[i] = rsp_vld && (rsp_id == PW'(i));
      if (transfer && (win == PW'(i))) begin
        add_a = req_a[i*WIDTH +: WIDTH];
        add_b = req_b[i*WIDTH +: WIDTH];
`ifdef PIPE_ARB_CHAIN_EN
        add_cin = req_chain[i] ? carry_q[i] : req_cin[i];
`else
        add_cin = req_cin[i];
`endif
      end
    end
  end

  assign rsp_sum  = rsp_vld ? add_sum : '0;
  assign rsp_cout = rsp_vld & add_cout;
  assign busy     = (|vld_q) & ~rst;

  always_comb begin
    ptr_d = ptr_q;
    if (transfer) ptr_d = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = transfer;
    id_d[0]  = win;
    for (int s = 1; s < LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      id_d[s]  = id_q[s-1];
    end
  end

  // Tag ids need no reset: they are only observed when their vld bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      vld_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
    end
    id_q <= id_d;
  end

endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// tb/tb_pipeline_adder_arbiter.sv - bench: external adder model, scheduled-response reference, directed + random stimulus
module tb_pipeline_adder_arbiter;
  localparam int WIDTH = 64;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int RING  = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready, req_cin, rsp_valid;
  logic [NREQ-1:0]       req_chain;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      add_a, add_b, add_sum, rsp_sum;
  logic                  add_cin, add_cout, rsp_cout, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
`ifdef PIPE_ARB_CHAIN_EN
    .req_chain(req_chain),
`endif
    .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  // External adder: LAT register stages, no reset.
  logic [WIDTH:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
  end
  assign add_sum  = apipe[LAT-1][WIDTH-1:0];
  assign add_cout = apipe[LAT-1][WIDTH];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: responses scheduled LAT cycles after each accepted request.
  int             cyc = 0;
  int             m_ptr = 0;
  logic           pend_v   [RING];
  int             pend_id  [RING];
  logic [WIDTH:0] pend_sum [RING];
  logic           m_carry  [NREQ];

  initial begin
    for (int s = 0; s < RING; s++) pend_v[s] = 1'b0;
    for (int i = 0; i < NREQ; i++) m_carry[i] = 1'b0;
  end

  always @(negedge clk) begin : model
    int slot, win, idx;
    logic found, ok, any, cin;
    logic [WIDTH-1:0] a, b;
    slot = cyc % RING;
    if (rst) begin
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      for (int s = 0; s < RING; s++) pend_v[s] = 1'b0;
      for (int i = 0; i < NREQ; i++) m_carry[i] = 1'b0;
      m_ptr = 0;
    end else begin
      any = 1'b0;
      for (int s = 0; s < RING; s++) any |= pend_v[s];
      check("m_busy", busy, any);
      if (pend_v[slot]) begin
        check("m_rsp_valid", rsp_valid, 1 << pend_id[slot]);
        check("m_rsp_sum", rsp_sum, pend_sum[slot][WIDTH-1:0]);
        check("m_rsp_cout", rsp_cout, pend_sum[slot][WIDTH]);
      end else begin
        check("m_rsp_idle", {rsp_valid, rsp_cout, rsp_sum}, 0);
      end
      found = 1'b0;
      win = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        ok = req_valid[idx];
`ifdef PIPE_ARB_CHAIN_EN
        if (req_chain[idx])
          for (int s = 0; s < RING; s++) if (pend_v[s] && pend_id[s] == idx) ok = 1'b0;
`endif
        if (!found && ok) begin found = 1'b1; win = idx; end
      end
      if (found) begin
        a = req_a[win*WIDTH +: WIDTH];
        b = req_b[win*WIDTH +: WIDTH];
        cin = req_cin[win];
`ifdef PIPE_ARB_CHAIN_EN
        if (req_chain[win]) cin = m_carry[win];
`endif
        check("m_ready", req_ready, 1 << win);
        check("m_add_ops", {add_cin, add_a, add_b}, {cin, a, b});
      end else begin
        check("m_ready_none", req_ready, 0);
        check("m_add_bubble", {add_cin, add_a, add_b}, 0);
      end
      if (pend_v[slot]) m_carry[pend_id[slot]] = pend_sum[slot][WIDTH];
      pend_v[slot] = 1'b0;
      if (found) begin
        pend_v[(cyc + LAT) % RING]   = 1'b1;
        pend_id[(cyc + LAT) % RING]  = win;
        pend_sum[(cyc + LAT) % RING] = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        m_ptr = (win + 1) % NREQ;
      end
    end
    cyc++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    req_valid[i] = 1'b1;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i] = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_chain = '0;
    next();
    next();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_chain = '0;
    req_cin = '0;
    req_a = '0;
    req_b = '0;
    next();

    // Single op: 5 + 7 + 1.
    do_reset();
    set_req(0, 64'd5, 64'd7, 1'b1);
    sample(); check("t1_ready", req_ready, 4'b0001);
    next(); req_valid = '0; sample();
    next(); sample();
    check("t1_rsp_valid", rsp_valid, 4'b0001);
    check("t1_rsp_sum", rsp_sum, 13);
    check("t1_rsp_cout", rsp_cout, 0);

    // All requesters valid: rotating grants, responses two cycles behind.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) for (int i = 0; i < NREQ; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      else req_valid = '0;
      sample();
      if (k < 8) check("t2_grant", req_ready, 1 << (k % NREQ));
      if (k >= 2) check("t2_rsp_order", rsp_valid, 1 << ((k - 2) % NREQ));
      next();
    end

    // All-ones + 1 wraps to zero with carry out.
    do_reset();
    set_req(3, '1, 64'd1, 1'b0);
    sample(); next(); req_valid = '0; sample(); next(); sample();
    check("t3_rsp_valid", rsp_valid, 4'b1000);
    check("t3_rsp_sum", rsp_sum, 0);
    check("t3_rsp_cout", rsp_cout, 1);

    // Pointer moves past req2; idle cycles drive a zero bubble.
    do_reset();
    set_req(2, 64'd9, 64'd9, 1'b0);
    sample(); check("t4_ready2", req_ready, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      next(); req_valid = '0; sample();
      check("t4_bubble", {add_cin, add_a, add_b}, 0);
    end
    next(); set_req(1, 64'd1, 64'd2, 1'b0); set_req(3, 64'd3, 64'd4, 1'b0);
    sample(); check("t4_first_req3", req_ready, 4'b1000);
    next(); sample(); check("t4_then_req1", req_ready, 4'b0010);
    next(); req_valid = '0;

    // Reset mid-flight discards ops and resets the pointer.
    do_reset();
    set_req(0, 64'd100, 64'd1, 1'b0);
    sample(); next(); req_valid = '0; set_req(1, 64'd200, 64'd2, 1'b0);
    sample(); next(); rst = 1'b1; req_valid = '1;
    sample();
    check("t5_rst_rsp", rsp_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", req_ready, 0);
    next(); rst = 1'b0; req_valid = 4'b0110;
    sample();
    check("t5_post_rsp", rsp_valid, 0);
    check("t5_post_busy", busy, 0);
    check("t5_post_ptr0", req_ready, 4'b0010);
    next(); req_valid = '0; sample();
    next(); sample();

`ifdef PIPE_ARB_CHAIN_EN
    // Two-word add: high word waits for the low word's carry.
    do_reset();
    set_req(1, '1, 64'd1, 1'b0);
    sample(); check("t6_low_ready", req_ready, 4'b0010);
    next(); set_req(1, 64'd0, 64'd0, 1'b0); req_chain[1] = 1'b1;
    sample(); check("t6_wait_c1", req_ready, 0);
    next(); sample(); check("t6_wait_c2", req_ready, 0);
    check("t6_low_rsp", {rsp_valid, rsp_cout, rsp_sum}, {4'b0010, 1'b1, 64'd0});
    next(); sample(); check("t6_high_ready", req_ready, 4'b0010);
    next(); req_valid = '0; req_chain = '0; sample();
    next(); sample();
    check("t6_high_rsp_valid", rsp_valid, 4'b0010);
    check("t6_high_rsp_sum", rsp_sum, 1);
    check("t6_high_rsp_cout", rsp_cout, 0);
`endif

    // Random traffic with occasional resets, checked by the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(63) == 0);
      req_valid = NREQ'($urandom);
      req_cin = NREQ'($urandom);
`ifdef PIPE_ARB_CHAIN_EN
      req_chain = NREQ'($urandom);
`endif
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*WIDTH +: WIDTH] = ($urandom_range(3) == 0) ? '1 : {$urandom, $urandom};
        req_b[i*WIDTH +: WIDTH] = ($urandom_range(3) == 0) ? 64'd1 : {$urandom, $urandom};
      end
      sample();
      next();
    end
    rst = 1'b0;
    req_valid = '0;
    req_chain = '0;
    repeat (4) begin sample(); next(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
